// File: rtl/stage_sequencer_if.sv
// Purpose: bundles the start/stall control and the read/write stage schedule
//          produced by stage_sequencer.
// Ports (signals):
//   start, stall          - pass control from the top-level sequencing logic
//   rd_stage/step/valid   - live read schedule
//   rd_lstep              - last step of the current read stage
//   wr_stage/valid/lstep  - read schedule delayed to match the datapath
//   busy, done            - pass status; done is a one-cycle pulse
// Modports: master = sequencer side, slave = controller/consumer side.
interface stage_sequencer_if #(
  parameter int N_STEP = 8
);
  localparam int SW = (N_STEP > 2) ? $clog2(N_STEP) : 1;

  logic          start;
  logic          stall;
  logic [3:0]    rd_stage;
  logic [SW-1:0] rd_step;
  logic          rd_valid;
  logic          rd_lstep;
  logic [3:0]    wr_stage;
  logic          wr_valid;
  logic          wr_lstep;
  logic          busy;
  logic          done;

  modport master (
    input  start, stall,
    output rd_stage, rd_step, rd_valid, rd_lstep,
    output wr_stage, wr_valid, wr_lstep, busy, done
  );

  modport slave (
    output start, stall,
    input  rd_stage, rd_step, rd_valid, rd_lstep,
    input  wr_stage, wr_valid, wr_lstep, busy, done
  );
endinterface

// File: rtl/stage_sequencer.sv
// Purpose: walks read stages 0..N_STAGE-1 of N_STEP cycles each and produces a
//          write-side copy of the schedule delayed by WR_LAG advancing cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, highest priority
//   bus  - stage_sequencer_if master: start/stall in, rd_*/wr_*/busy/done out
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; all outputs 0
// RUN   | read schedule live, step/stage counters advance when !stall
// DRAIN | read side off, delay pipeline flushes WR_LAG advancing cycles
// DONE  | one-cycle done pulse, start ignored, back to IDLE
module stage_sequencer #(
  parameter int N_STEP  = 8,
  parameter int N_STAGE = 12,
  parameter int WR_LAG  = 2
) (
  input  logic              clk,
  input  logic              rst,
  stage_sequencer_if.master bus
);
  localparam int SW = (N_STEP > 2) ? $clog2(N_STEP) : 1;
  localparam int DW = (WR_LAG > 2) ? $clog2(WR_LAG) : 1;

  localparam logic [SW-1:0] LAST_STEP  = SW'(N_STEP - 1);
  localparam logic [3:0]    LAST_STAGE = 4'(N_STAGE - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(WR_LAG - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] step;
  logic [3:0]    stage;
  logic          valid;
  logic [DW-1:0] drain_cnt;
  // each entry is {valid, stage, lstep}; zeros whenever valid is 0
  logic [5:0]    pipe [WR_LAG];
  logic          lstep;
  logic          busy;
  logic          hold;

  assign lstep = valid && (step == LAST_STEP);
  assign busy  = (state == S_RUN) || (state == S_DRAIN);
  // stall only freezes an active pass
  assign hold  = bus.stall && busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      stage     <= '0;
      valid     <= 1'b0;
      drain_cnt <= '0;
      for (int i = 0; i < WR_LAG; i++) pipe[i] <= '0;
    end else if (!hold) begin
      pipe[0] <= {valid, stage, lstep};
      for (int i = 1; i < WR_LAG; i++) pipe[i] <= pipe[i-1];

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            valid <= 1'b1;
            step  <= '0;
            stage <= '0;
          end
        end
        S_RUN: begin
          if (step == LAST_STEP) begin
            step <= '0;
            if (stage == LAST_STAGE) begin
              state     <= S_DRAIN;
              valid     <= 1'b0;
              stage     <= '0;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              stage <= stage + 4'd1;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_DONE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_stage = stage;
  assign bus.rd_step  = step;
  assign bus.rd_valid = valid;
  assign bus.rd_lstep = lstep;
  assign bus.wr_valid = pipe[WR_LAG-1][5];
  assign bus.wr_stage = pipe[WR_LAG-1][4:1];
  assign bus.wr_lstep = pipe[WR_LAG-1][0];
  assign bus.busy     = busy;
  assign bus.done     = (state == S_DONE);
endmodule
